// File: rtl/qea_run_sequencer.sv
// qea_run_sequencer: loads gate contexts and |0..0>, runs QEA, counts cycles, streams the state back.
// Optional watchdog on the run phase: define QEA_SEQ_TIMEOUT_EN.
module qea_run_sequencer #(
  parameter int PE_NUM_WIDTH = 2,
  parameter int PE_NUM = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH*2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH = 6,
  parameter int NUM_FRAC_BIT = 30
`ifdef QEA_SEQ_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cmd_valid,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cmd_ins_num,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic [31:0]                          o_exec_cycles,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);
  localparam int SW = PE_NUM*STATE_DATA_WIDTH;
  localparam int CW = (GATE_CONTEXT_ADDR_WIDTH > STATE_ADDR_WIDTH ? GATE_CONTEXT_ADDR_WIDTH : STATE_ADDR_WIDTH) + 1;
  localparam logic [MAX_QBIT_WIDTH-1:0] q_min = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] q_max = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  // amplitude 1.0 sits in the real half of the most-significant slot
  localparam logic [SW-1:0] init_word = SW'(DATA_WIDTH'(1) << NUM_FRAC_BIT) << (SW - DATA_WIDTH);

  typedef enum logic [3:0] {IDLE, LOAD_CTX, INIT_ST, START, RUN, RD_ISSUE, RD_WAIT, RD_HOLD, DONE} state_t;

  state_t                        state;
  logic [GATE_CONTEXT_ADDR_WIDTH:0] n;
  logic [MAX_QBIT_WIDTH-1:0]     q;
  logic [CW-1:0]                 idx;
  logic [CW-1:0]                 last_idx;
  logic                          err;
  logic [31:0]                   exec;
  logic [SW-1:0]                 hold;
  logic                          bad_q;
  logic                          ctx_last;

  assign bad_q    = i_cmd_qbit_num < q_min || i_cmd_qbit_num > q_max;
  assign last_idx = (CW'(1) << (q - q_min)) - CW'(1);
  assign ctx_last = idx + CW'(1) == CW'(n);

  assign o_busy         = state != IDLE && state != DONE;
  assign o_done         = state == DONE;
  assign o_err          = err;
  assign o_ctx_ready    = state == LOAD_CTX;
  assign o_ctx_en       = o_ctx_ready && i_ctx_valid;
  assign o_ctx_wea      = o_ctx_en;
  assign o_ctx_addr     = o_ctx_en ? idx[GATE_CONTEXT_ADDR_WIDTH-1:0] : '0;
  assign o_ctx_data     = o_ctx_en ? i_ctx_data : '0;
  assign o_state_ena    = state == INIT_ST || state == RD_ISSUE;
  assign o_state_wea    = state == INIT_ST;
  assign o_state_addra  = o_state_ena ? idx[STATE_ADDR_WIDTH-1:0] : '0;
  assign o_state_dina   = (o_state_wea && idx == '0) ? init_word : '0;
  assign o_rd_valid     = state == RD_HOLD;
  assign o_rd_data      = hold;
  assign o_exec_cycles  = exec;
  assign o_qea_start    = state == START;
  assign o_qea_qbit_num = q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      q     <= '0;
      idx   <= '0;
      err   <= 1'b0;
      exec  <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: if (i_cmd_valid) begin
          n     <= i_cmd_ins_num;
          q     <= i_cmd_qbit_num;
          idx   <= '0;
          exec  <= '0;
          err   <= bad_q;
          state <= bad_q ? DONE : (i_cmd_ins_num == '0 ? INIT_ST : LOAD_CTX);
        end
        LOAD_CTX: if (i_ctx_valid) begin
          idx   <= ctx_last ? '0 : idx + CW'(1);
          state <= ctx_last ? INIT_ST : LOAD_CTX;
        end
        INIT_ST: begin
          idx   <= idx == last_idx ? '0 : idx + CW'(1);
          state <= idx == last_idx ? START : INIT_ST;
        end
        START: state <= RUN;
        RUN: begin
          exec <= &exec ? exec : exec + 32'd1;
          if (i_qea_complete) state <= RD_ISSUE;
`ifdef QEA_SEQ_TIMEOUT_EN
          else if (exec + 32'd1 == TIMEOUT_CYCLES) begin
            err   <= 1'b1;
            state <= DONE;
          end
`endif
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          hold  <= i_qea_state_dout;
          state <= RD_HOLD;
        end
        RD_HOLD: if (i_rd_ready) begin
          idx   <= idx + CW'(1);
          state <= idx == last_idx ? DONE : RD_ISSUE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/qea_run_sequencer.md
Name: qea_run_sequencer

Overview:
- Host-side run controller for the QEA quantum-emulation core; replaces bench-driven sequencing.
- One run command triggers four phases in order: stream N gate-context words into CTX RAM, write the |0…0> initial state into STATE RAM, pulse start and wait for complete, then stream the final state vector back out.
- Measures execution cycles from start to complete.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE count.
- PE_NUM, 4, PEs per state word.
- DATA_WIDTH, 32, real/imag component width.
- STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude.
- STATE_ADDR_WIDTH, 16, STATE RAM address width.
- GATE_CONTEXT_DATA_WIDTH, DATA_WIDTH*2, context word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, CTX RAM address width.
- MAX_QBIT_WIDTH, 6, qubit-count field width.
- NUM_FRAC_BIT, 30, fraction bits; amplitude 1.0 = 1<<NUM_FRAC_BIT in the real half.
- TIMEOUT_CYCLES, 32'd1000000, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_cmd_valid  in  1  run request pulse.
- i_cmd_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  context word count N.
- i_cmd_qbit_num  in  MAX_QBIT_WIDTH  qubit count Q.
- o_busy  out  1  high from command accept until return to IDLE.
- o_done  out  1  one-cycle pulse at run end.
- o_err  out  1  sticky until next accepted command; bad Q or timeout.
- i_ctx_valid / o_ctx_ready / i_ctx_data  in/out/in  1/1/GATE_CONTEXT_DATA_WIDTH  context word stream.
- o_rd_valid / i_rd_ready / o_rd_data  out/in/out  1/1/PE_NUM*STATE_DATA_WIDTH  state readback stream.
- o_exec_cycles  out  32  cycles from start pulse to complete.
- o_qea_start, o_qea_qbit_num  out  1, MAX_QBIT_WIDTH  to QEA.
- o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data  out  1,1,GATE_CONTEXT_ADDR_WIDTH,GATE_CONTEXT_DATA_WIDTH  to QEA CTX port.
- o_state_ena, o_state_wea, o_state_addra, o_state_dina  out  1,1,STATE_ADDR_WIDTH,PE_NUM*STATE_DATA_WIDTH  to QEA STATE port.
- i_qea_complete, i_qea_state_dout  in  1, PE_NUM*STATE_DATA_WIDTH  from QEA.

Behaviour:
- Reset (async, immediate, including mid-run): every output 0, FSM=IDLE, counters 0.
- FSM: IDLE -> LOAD_CTX -> INIT_ST -> START -> RUN -> RD_ISSUE -> RD_WAIT -> RD_HOLD -> DONE -> IDLE.
- IDLE: accept i_cmd_valid; latch N and Q; clear o_err, o_exec_cycles.
  - Q < PE_NUM_WIDTH or Q > STATE_ADDR_WIDTH+PE_NUM_WIDTH: set o_err, go DONE.
  - i_cmd_valid outside IDLE is ignored.
- State depth D = 2**(Q-PE_NUM_WIDTH) words; Q = PE_NUM_WIDTH gives D = 1.
- LOAD_CTX:
  - o_ctx_ready=1; each handshake drives o_ctx_en=o_ctx_wea=1 with addr k (0..N-1) and data for exactly that cycle.
  - Leave after the N-th handshake; N=0 skips directly to INIT_ST with ready never asserted.
- INIT_ST: one write per cycle, addr 0..D-1.
  - Word 0 dina: most-significant amplitude slot = {1<<NUM_FRAC_BIT, 0}, all other slots 0.
  - Words 1..D-1: dina = 0.
- START: o_qea_start=1 for exactly one cycle; o_qea_qbit_num = Q held stable from command accept to DONE.
- RUN:
  - o_exec_cycles increments every cycle, saturating at all-ones.
  - i_qea_complete is sampled only in RUN; leave RUN on complete.
- Readback: RAM read latency is 1 cycle.
  - RD_ISSUE: ena=1, wea=0, addr r.
  - RD_WAIT: capture i_qea_state_dout into the hold register.
  - RD_HOLD: o_rd_valid=1, data stable until i_rd_ready. On handshake, r+1 < D goes to RD_ISSUE; otherwise DONE.
  - Throughput: one word per 3 cycles maximum.
- DONE: o_done pulse for one cycle, o_busy drops in the same cycle, then IDLE.

Optional Feature:
- Macro QEA_SEQ_TIMEOUT_EN.
- Defined: if RUN reaches o_exec_cycles == TIMEOUT_CYCLES without complete, set o_err, skip readback, go DONE.
- Undefined: RUN waits indefinitely; TIMEOUT_CYCLES is unused; no extra logic.

Test Plan:
- Q=4, N=133, complete 50 cycles after start -> 133 ctx writes addr 0..132 in order; 4 state writes, word0 top slot 0x40000000_00000000; one start pulse; o_exec_cycles=50; 4 readback words; o_done once.
- N=0, Q=2 -> ctx_ready never high; exactly 1 init write and 1 readback word; done.
- Q=1 -> o_err=1, o_done pulse, no RAM or start activity; next valid command clears o_err.
- i_rd_ready held low 20 cycles on word 2 -> o_rd_valid and data stable, no new RAM read issued; resumes on ready.
- rst asserted mid-LOAD_CTX -> all outputs 0 asynchronously; new command restarts at ctx addr 0.
- With QEA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, complete never asserted -> o_err=1 at cycle 100 of RUN, no readback, o_done pulse.
